// File: rtl/pixel_array_readout.sv
// Pixel array read side: row-by-row capture of the column bus,
// then row-major streaming of the codes over valid/ready.
module pixel_array_readout #(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   START,
  output logic [ROWS-1:0]                        ROW_SELECT,
  input  logic [COLS*DATA_WIDTH-1:0]             PIXEL_BUS,
  output logic [DATA_WIDTH-1:0]                  OUT_DATA,
  output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] OUT_ROW,
  output logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] OUT_COL,
  output logic                                   OUT_LAST,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic                                   BUSY,
  output logic                                   FRAME_DONE
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(READ_LATENCY - 1);
  localparam logic          ONE_COL   = (COLS == 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CAPTURE,
    STREAM,
    DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] row_buf [COLS];
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [CW-1:0]         col_next;
  logic [WW-1:0]         wait_cnt;
  logic                  xfer;
  logic                  row_is_last;
  logic                  col_is_last;

  function automatic logic [ROWS-1:0] onehot(input logic [RW-1:0] r);
    logic [ROWS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Handshake and position decode for the streaming state
  always_comb begin
    xfer        = OUT_VALID && OUT_READY;
    col_next    = col + 1'b1;
    row_is_last = (row == LAST_ROW);
    col_is_last = (col == LAST_COL);
  end

  // Readout FSM with registered array strobes and stream outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      wait_cnt   <= '0;
      ROW_SELECT <= '0;
      OUT_DATA   <= '0;
      OUT_ROW    <= '0;
      OUT_COL    <= '0;
      OUT_LAST   <= 1'b0;
      OUT_VALID  <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        row_buf[c] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            state      <= SELECT;
            row        <= '0;
            col        <= '0;
            ROW_SELECT <= onehot('0);
            BUSY       <= 1'b1;
            wait_cnt   <= WAIT_INIT;
          end
        end

        SELECT: begin
          if (wait_cnt == '0) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        CAPTURE: begin
          for (int c = 0; c < COLS; c++) begin
            row_buf[c] <= PIXEL_BUS[c*DATA_WIDTH +: DATA_WIDTH];
          end
          ROW_SELECT <= '0;
          state      <= STREAM;
          col        <= '0;
          OUT_VALID  <= 1'b1;
          OUT_DATA   <= PIXEL_BUS[0 +: DATA_WIDTH];
          OUT_ROW    <= row;
          OUT_COL    <= '0;
          OUT_LAST   <= row_is_last && ONE_COL;
        end

        STREAM: begin
          if (xfer) begin
            if (!col_is_last) begin
              col      <= col_next;
              OUT_DATA <= row_buf[col_next];
              OUT_COL  <= col_next;
              OUT_LAST <= row_is_last && (col_next == LAST_COL);
            end else begin
              col       <= '0;
              OUT_VALID <= 1'b0;
              OUT_LAST  <= 1'b0;
              OUT_DATA  <= '0;
              OUT_ROW   <= '0;
              OUT_COL   <= '0;
              if (!row_is_last) begin
                row        <= row + 1'b1;
                ROW_SELECT <= onehot(row + 1'b1);
                wait_cnt   <= WAIT_INIT;
                state      <= SELECT;
              end else begin
                FRAME_DONE <= 1'b1;
                state      <= DONE;
              end
            end
          end
        end

        DONE: begin
          state      <= IDLE;
          FRAME_DONE <= 1'b0;
          BUSY       <= 1'b0;
          row        <= '0;
          col        <= '0;
        end

        default: begin
          state      <= IDLE;
          ROW_SELECT <= '0;
          OUT_VALID  <= 1'b0;
          OUT_LAST   <= 1'b0;
          BUSY       <= 1'b0;
          FRAME_DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_readout.sv
// Directed bench for pixel_array_readout: default 2x2 instance
// plus a 1x4 instance with READ_LATENCY=3.
module tb_pixel_array_readout;

  logic        clk;
  logic        rst;

  logic        start;
  logic [1:0]  row_select;
  logic [15:0] pixel_bus;
  logic [7:0]  out_data;
  logic [0:0]  out_row;
  logic [0:0]  out_col;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        frame_done;

  logic        start2;
  logic [0:0]  rs2;
  logic [31:0] pb2;
  logic [7:0]  od2;
  logic [0:0]  or2;
  logic [1:0]  oc2;
  logic        ol2;
  logic        ov2;
  logic        ord2;
  logic        busy2;
  logic        fd2;

  logic        manual;
  logic [15:0] man_bus;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_d [4];

  pixel_array_readout u_dut (
    .CLK        (clk),
    .RESET      (rst),
    .START      (start),
    .ROW_SELECT (row_select),
    .PIXEL_BUS  (pixel_bus),
    .OUT_DATA   (out_data),
    .OUT_ROW    (out_row),
    .OUT_COL    (out_col),
    .OUT_LAST   (out_last),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .BUSY       (busy),
    .FRAME_DONE (frame_done)
  );

  pixel_array_readout #(
    .ROWS         (1),
    .COLS         (4),
    .DATA_WIDTH   (8),
    .READ_LATENCY (3)
  ) u_dut2 (
    .CLK        (clk),
    .RESET      (rst),
    .START      (start2),
    .ROW_SELECT (rs2),
    .PIXEL_BUS  (pb2),
    .OUT_DATA   (od2),
    .OUT_ROW    (or2),
    .OUT_COL    (oc2),
    .OUT_LAST   (ol2),
    .OUT_VALID  (ov2),
    .OUT_READY  (ord2),
    .BUSY       (busy2),
    .FRAME_DONE (fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: selected row drives the shared column bus
  always_comb begin
    if (manual)
      pixel_bus = man_bus;
    else if (row_select[1])
      pixel_bus = 16'hFFAB;
    else if (row_select[0])
      pixel_bus = 16'h3412;
    else
      pixel_bus = 16'h5555;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input int mid_start);
    int nw;
    int nfd;
    nw  = 0;
    nfd = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 30; cyc++) begin
      start = (cyc == mid_start);
      if (out_valid) begin
        if (nw < 4) begin
          chk({tag, "_data"}, out_data, exp_d[nw]);
          chk({tag, "_row"}, out_row, nw / 2);
          chk({tag, "_col"}, out_col, nw % 2);
          chk({tag, "_last"}, out_last, nw == 3);
        end
        nw++;
      end
      if (frame_done) nfd++;
      tick();
    end
    start = 1'b0;
    chk({tag, "_words"}, nw, 4);
    chk({tag, "_done_cnt"}, nfd, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    exp_d[0] = 8'h12;
    exp_d[1] = 8'h34;
    exp_d[2] = 8'hAB;
    exp_d[3] = 8'hFF;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    out_ready = 1'b0;
    ord2 = 1'b1;
    manual = 1'b0;
    man_bus = '0;
    pb2 = 32'hFF80_0100;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rs", row_select, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rs2", rs2, 0);
    chk("rst_valid2", ov2, 0);

    // Basic frame, ready held high (ready while idle is harmless)
    out_ready = 1'b1;
    tick();
    chk("idle_valid", out_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_k1_rs", row_select, 2'b01);
    chk("b_k1_busy", busy, 1);
    chk("b_k1_valid", out_valid, 0);
    tick();
    chk("b_k2_rs", row_select, 2'b01);
    chk("b_k2_valid", out_valid, 0);
    tick();
    chk("b_k3_valid", out_valid, 1);
    chk("b_k3_data", out_data, 8'h12);
    chk("b_k3_rc", {out_row, out_col}, 2'b00);
    chk("b_k3_last", out_last, 0);
    chk("b_k3_rs", row_select, 0);
    tick();
    chk("b_k4_data", out_data, 8'h34);
    chk("b_k4_rc", {out_row, out_col}, 2'b01);
    chk("b_k4_last", out_last, 0);
    tick();
    chk("b_k5_valid", out_valid, 0);
    chk("b_k5_rs", row_select, 2'b10);
    tick();
    chk("b_k6_rs", row_select, 2'b10);
    tick();
    chk("b_k7_valid", out_valid, 1);
    chk("b_k7_data", out_data, 8'hAB);
    chk("b_k7_rc", {out_row, out_col}, 2'b10);
    chk("b_k7_last", out_last, 0);
    tick();
    chk("b_k8_data", out_data, 8'hFF);
    chk("b_k8_rc", {out_row, out_col}, 2'b11);
    chk("b_k8_last", out_last, 1);
    chk("b_k8_done", frame_done, 0);
    tick();
    chk("b_k9_valid", out_valid, 0);
    chk("b_k9_done", frame_done, 1);
    chk("b_k9_busy", busy, 1);
    tick();
    chk("b_k10_done", frame_done, 0);
    chk("b_k10_busy", busy, 0);

    // Backpressure on word (0,1)
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("bp_w0", out_data, 8'h12);
    tick();
    chk("bp_w1", out_data, 8'h34);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h34);
      chk("bp_hold_col", out_col, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", out_valid, 0);
    tick();
    tick();
    chk("bp_w2", out_data, 8'hAB);
    chk("bp_w2_rc", {out_row, out_col}, 2'b10);
    tick();
    chk("bp_w3", out_data, 8'hFF);
    chk("bp_w3_last", out_last, 1);
    tick();
    chk("bp_done", frame_done, 1);
    tick();

    // START pulsed during STREAM is ignored
    run_frame("ign", 3);

    // Reset during row 1 SELECT
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("mr_sel_row1", row_select, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_rs", row_select, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", frame_done, 0);
    chk("mr_outs", {out_data, out_row, out_col, out_last}, 0);
    run_frame("mr_new", 0);

    // Bus isolation: bus changes every cycle except at CAPTURE
    manual = 1'b1;
    man_bus = 16'h1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    man_bus = 16'h2222;
    tick();
    man_bus = 16'h5AC3;
    tick();
    man_bus = 16'h3333;
    chk("iso_w0", out_data, 8'hC3);
    tick();
    man_bus = 16'h4444;
    chk("iso_w1", out_data, 8'h5A);
    tick();
    man_bus = 16'h6666;
    chk("iso_sel", row_select, 2'b10);
    tick();
    man_bus = 16'h0FE1;
    tick();
    man_bus = 16'h7777;
    chk("iso_w2", out_data, 8'hE1);
    tick();
    man_bus = 16'h8888;
    chk("iso_w3", out_data, 8'h0F);
    chk("iso_w3_last", out_last, 1);
    tick();
    chk("iso_done", frame_done, 1);
    tick();
    manual = 1'b0;

    // Second instance: READ_LATENCY=3, one row, four columns
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("l_rs_hi", rs2, 1);
      chk("l_valid_lo", ov2, 0);
      tick();
    end
    chk("l_k5_valid", ov2, 1);
    chk("l_k5_rs", rs2, 0);
    chk("l_k5_data", od2, 8'h00);
    chk("l_k5_idx", {or2, oc2}, 0);
    chk("l_k5_last", ol2, 0);
    tick();
    chk("l_k6_data", od2, 8'h01);
    chk("l_k6_col", oc2, 1);
    tick();
    chk("l_k7_data", od2, 8'h80);
    chk("l_k7_col", oc2, 2);
    chk("l_k7_last", ol2, 0);
    tick();
    chk("l_k8_data", od2, 8'hFF);
    chk("l_k8_col", oc2, 3);
    chk("l_k8_row", or2, 0);
    chk("l_k8_last", ol2, 1);
    tick();
    chk("l_k9_valid", ov2, 0);
    chk("l_k9_done", fd2, 1);
    tick();
    chk("l_k10_busy", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_array_readout.md
Name: pixel_array_readout

Overview:
- Read side of the pixel array data path. The pixel array counter writes a code into each pixel during conversion; this block reads those codes back out once conversion ends.
- On a START pulse it selects each row in turn and captures that row's codes from the shared column bus.
- It then streams the codes one word at a time to the downstream interface using a valid/ready handshake, in row-major order, row 0 column 0 first.

Parameters:
- ROWS, 2, number of pixel rows (≥1).
- COLS, 2, number of pixel columns (≥1).
- DATA_WIDTH, 8, bits per pixel code; equals the pixel array counter width.
- READ_LATENCY, 1, cycles from a ROW_SELECT assertion until PIXEL_BUS is valid (≥1).

Ports:
- CLK  input  1  single clock for all logic.
- RESET  input  1  reset; one clock; reset is synchronous and active-high.
- START  input  1  one-cycle pulse that begins a frame readout; honoured only in IDLE.
- ROW_SELECT  output  ROWS  one-hot row read enable to the array.
- PIXEL_BUS  input  COLS*DATA_WIDTH  codes of the selected row; column c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- OUT_DATA  output  DATA_WIDTH  current pixel code.
- OUT_ROW  output  max(1,$clog2(ROWS))  row index of OUT_DATA.
- OUT_COL  output  max(1,$clog2(COLS))  column index of OUT_DATA.
- OUT_LAST  output  1  high with the final word of the frame.
- OUT_VALID  output  1  OUT_* fields are valid.
- OUT_READY  input  1  downstream accepts the word.
- BUSY  output  1  high from the cycle after START is accepted through the FRAME_DONE cycle.
- FRAME_DONE  output  1  one-cycle pulse after the last word is transferred.

Behaviour:
- Reset, including mid-frame: state IDLE; all outputs 0; row buffer, row counter and column counter cleared. The array needs no abort sequence.
- All outputs are registered.
- FSM states: IDLE, SELECT, CAPTURE, STREAM, DONE.
- IDLE: START=1 at edge k moves to SELECT. From k+1 onward: ROW_SELECT = one-hot(row), BUSY=1, wait counter loaded.
- SELECT: holds ROW_SELECT for READ_LATENCY cycles, then moves to CAPTURE.
- CAPTURE (one cycle):
  - PIXEL_BUS is latched into the internal row buffer.
  - ROW_SELECT drops to 0 at the next edge.
  - The FSM moves to STREAM with col=0 and OUT_VALID=1.
  - Row 0: START at edge k gives the first OUT_VALID at k+READ_LATENCY+2.
- STREAM:
  - OUT_DATA = buffer[col], OUT_ROW = row, OUT_COL = col.
  - Transfer occurs on any edge with OUT_VALID=1 and OUT_READY=1.
  - While OUT_VALID=1 and OUT_READY=0, all OUT_* fields are held stable. OUT_VALID never drops without a transfer.
  - After a transfer with col<COLS-1: col+1 is presented on the next cycle, back-to-back (one word per cycle at full throughput).
  - After a transfer with col=COLS-1 and row<ROWS-1: OUT_VALID=0, row+1, back to SELECT.
  - After a transfer with col=COLS-1 and row=ROWS-1: OUT_VALID=0, go to DONE.
- OUT_LAST = 1 exactly when OUT_VALID=1, row=ROWS-1 and col=COLS-1.
- DONE (one cycle): FRAME_DONE=1, BUSY=1. Next state is IDLE, with BUSY=0 and counters cleared.
- START while not in IDLE is ignored, with no queuing. START in the same cycle as RESET is ignored.
- OUT_READY may be high while OUT_VALID=0; it has no effect.
- ROWS=1 or COLS=1: index outputs are 1 bit wide, tied to 0.
- ROW_SELECT is never more than one-hot and is 0 outside SELECT/CAPTURE.
- PIXEL_BUS is sampled only in CAPTURE; changes at any other time are ignored.

Test Plan:
- Basic frame (defaults, OUT_READY=1): bus row0={0x12,0x34}, row1={0xAB,0xFF}; START at k.
  - ROW_SELECT=01 at k+1..k+2.
  - Words (r,c,data) in order: (0,0,12) at k+3, (0,1,34) at k+4, (1,0,AB), (1,1,FF).
  - OUT_LAST only on (1,1); FRAME_DONE one cycle later, then BUSY=0.
- Backpressure: OUT_READY=0 for 5 cycles while (0,1,34) is presented. OUT_DATA, OUT_COL and OUT_VALID stay constant; on release the next word follows in order; no word is lost or duplicated.
- START ignored: pulse START while in STREAM. Exactly 4 words and one FRAME_DONE; IDLE is reached with no second frame.
- Reset mid-frame: assert RESET during row 1 SELECT. Next cycle all outputs are 0 and the state is IDLE. A new START gives a full frame beginning at (0,0).
- Latency and boundary: READ_LATENCY=3, ROWS=1, COLS=4, bus={00,01,80,FF}.
  - ROW_SELECT is high for 4 cycles; the first word appears at k+5.
  - Codes 0x00 and 0xFF are passed unmodified; OUT_LAST is on column 3.
- Bus isolation: change PIXEL_BUS every cycle outside CAPTURE. Streamed data equals only the value present at the CAPTURE edge.
